flopoco_conv_arbiter: RTL and testbench

Shares one fixed-latency FloPoCo-to-IEEE-754 double converter among `LANES` MAC result streams. Each lane pushes FloPoCo-format results into a small per-lane skid buffer. A round-robin arbiter issues at most one result per cycle to the converter and tags it with its lane number. The lane-tagged IEEE result is written to a credit-protected output FIFO, so a downstream stall never loses data inside the non-stallable converter pipeline.

---
 rtl/flopoco_pkg.sv | 19 +
 rtl/flopoco_conv_arbiter_out_fifo.sv | 79 +++++++
 rtl/flopoco_conv_arbiter.sv | 221 ++++++++++++++++++++++
 tb/tb_flopoco_conv_arbiter.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/flopoco_pkg.sv
// rtl/flopoco_pkg.sv - shared word types and helpers for the FloPoCo converter arbiter
//
// Purpose: common widths and word types for the FloPoCo (66-bit) to IEEE-754
// double (64-bit) path, plus a small lane-index wrap helper used by the arbiter.
// Ports: none (package).
package flopoco_pkg;

    localparam int FP_W   = 66;
    localparam int IEEE_W = 64;

    typedef logic [FP_W-1:0]   fp_word_t;
    typedef logic [IEEE_W-1:0] ieee_word_t;

    // idx is at most 2*lanes-2, so a single conditional subtract wraps it.
    function automatic int wrap_lane(input int idx, input int lanes);
        return (idx >= lanes) ? (idx - lanes) : idx;
    endfunction

endpackage

// File: rtl/flopoco_conv_arbiter_out_fifo.sv
// rtl/flopoco_conv_arbiter_out_fifo.sv - fall-through output FIFO with occupancy count
//
// Module arb_out_fifo.
// Purpose: synchronous FIFO whose head is visible combinationally on rd_data
// (fall-through). rd_data reads as zero while empty.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   wr_en, wr_data    write strobe and word (ignored when full)
//   rd_en             pop the head (ignored when empty)
//   rd_data           current head word
//   count             number of stored words (0..DEPTH)
//   empty             count == 0
module arb_out_fifo #(
    parameter int W     = 66,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic [W-1:0]             wr_data,
    input  logic                     rd_en,
    output logic [W-1:0]             rd_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [W-1:0]  mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_wr, do_rd;

    always_comb begin
        do_wr    = wr_en && (count_q != CW'(DEPTH));
        do_rd    = rd_en && (count_q != '0);
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_wr) begin
            mem_d[wr_ptr_q] = wr_data;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (do_rd) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        // Simultaneous write and read leave the occupancy unchanged.
        case ({do_wr, do_rd})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rd_data = empty ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/flopoco_conv_arbiter.sv
// rtl/flopoco_conv_arbiter.sv - round-robin sharing of one FloPoCo-to-IEEE converter
//
// Purpose: LANES MAC result streams push FloPoCo words into 2-entry skid
// buffers; a round-robin arbiter issues one word per cycle to an external
// fixed-latency converter; a tag line follows each word through the converter
// and the lane-tagged IEEE result lands in a credit-protected output FIFO.
// Optional feature macro: FLOPOCO_ARB_ERR_EN adds err_overflow and a drop check.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   req_push/req_data     per-lane push and FloPoCo word (lane i at [66i+65:66i])
//   req_stall             registered per-lane stall
//   conv_push/conv_x      registered issue strobe and word to the converter
//   conv_r                converter result, valid CONV_LAT cycles after conv_push
//   out_push/out_ieee     output valid and IEEE double (FIFO head)
//   out_lane              source lane of out_ieee
//   out_stall             downstream stall (combinational)
//   err_overflow          sticky per-lane drop flag (FLOPOCO_ARB_ERR_EN only)
module flopoco_conv_arbiter
    import flopoco_pkg::*;
#(
    parameter int LANES     = 4,
    parameter int CONV_LAT  = 3,
    parameter int OUT_DEPTH = 8,
    parameter int TAG_W     = $clog2(LANES)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [LANES-1:0]      req_push,
    input  logic [LANES*FP_W-1:0] req_data,
    output logic [LANES-1:0]      req_stall,
    output logic                  conv_push,
    output logic [FP_W-1:0]       conv_x,
    input  logic [IEEE_W-1:0]     conv_r,
    output logic                  out_push,
    output logic [IEEE_W-1:0]     out_ieee,
    output logic [TAG_W-1:0]      out_lane,
    input  logic                  out_stall
`ifdef FLOPOCO_ARB_ERR_EN
    ,
    output logic [LANES-1:0]      err_overflow
`endif
);

    typedef logic [TAG_W-1:0] lane_tag_t;

    localparam int CNT_W = $clog2(OUT_DEPTH) + 1;

    // Skid buffers: slot0 is always the head.
    fp_word_t   slot0_q [LANES];
    fp_word_t   slot0_d [LANES];
    fp_word_t   slot1_q [LANES];
    fp_word_t   slot1_d [LANES];
    logic [1:0] cnt_q   [LANES];
    logic [1:0] cnt_d   [LANES];
    logic [LANES-1:0] stall_q, stall_d;
    logic [LANES-1:0] pop, drop;

    // Arbiter and issue register.
    lane_tag_t  ptr_q, ptr_d;
    logic       grant_vld;
    lane_tag_t  grant_idx;
    logic       conv_push_q, conv_push_d;
    fp_word_t   conv_x_q, conv_x_d;
    lane_tag_t  conv_lane_q, conv_lane_d;

    // Tag line shadowing the converter pipeline.
    logic [CONV_LAT-1:0] tag_vld_q, tag_vld_d;
    lane_tag_t           tag_lane_q [CONV_LAT];
    lane_tag_t           tag_lane_d [CONV_LAT];

    // Credits.
    logic [CNT_W-1:0] fifo_count;
    logic [CNT_W-1:0] inflight;
    logic [CNT_W:0]   used;
    logic             credit_ok;

    logic                    fifo_empty;
    logic [IEEE_W+TAG_W-1:0] fifo_rd_data;

    // The issue register holds a word that is committed to the converter but
    // not yet in the tag line, so it consumes a credit too; otherwise a grant
    // made while the FIFO is one short of full could overflow it.
    always_comb begin
        inflight = CNT_W'(conv_push_q);
        for (int k = 0; k < CONV_LAT; k++) begin
            inflight = inflight + CNT_W'(tag_vld_q[k]);
        end
        used      = {1'b0, fifo_count} + {1'b0, inflight};
        credit_ok = (used < (CNT_W+1)'(OUT_DEPTH));
    end

    // Round-robin search: walking k downwards makes the smallest offset from
    // ptr the last (winning) assignment.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        for (int k = LANES - 1; k >= 0; k--) begin
            if (cnt_q[wrap_lane(int'(ptr_q) + k, LANES)] != 2'd0) begin
                grant_vld = 1'b1;
                grant_idx = lane_tag_t'(wrap_lane(int'(ptr_q) + k, LANES));
            end
        end
        grant_vld = grant_vld && credit_ok;

        ptr_d = ptr_q;
        if (grant_vld) begin
            ptr_d = (int'(grant_idx) == LANES - 1) ? '0 : grant_idx + 1'b1;
        end
    end

    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            pop[i]     = grant_vld && (grant_idx == lane_tag_t'(i));
            drop[i]    = req_push[i] && (cnt_q[i] == 2'd2);
            slot0_d[i] = slot0_q[i];
            slot1_d[i] = slot1_q[i];
            cnt_d[i]   = cnt_q[i];
            if (pop[i]) begin
                slot0_d[i] = slot1_q[i];
                cnt_d[i]   = cnt_q[i] - 2'd1;
            end
            if (req_push[i] && !drop[i]) begin
                if (cnt_d[i] == 2'd0) begin
                    slot0_d[i] = req_data[i*FP_W +: FP_W];
                end else begin
                    slot1_d[i] = req_data[i*FP_W +: FP_W];
                end
                cnt_d[i] = cnt_d[i] + 2'd1;
            end
            // A lane that is being drained this cycle keeps stall low, which
            // lets a lone lane stream one word per cycle.
            stall_d[i] = (cnt_d[i] != 2'd0) && !pop[i];
        end
    end

    always_comb begin
        conv_push_d = grant_vld;
        conv_x_d    = grant_vld ? slot0_q[grant_idx] : conv_x_q;
        conv_lane_d = grant_vld ? grant_idx : conv_lane_q;

        tag_vld_d[0]  = conv_push_q;
        tag_lane_d[0] = conv_lane_q;
        for (int k = 1; k < CONV_LAT; k++) begin
            tag_vld_d[k]  = tag_vld_q[k-1];
            tag_lane_d[k] = tag_lane_q[k-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < LANES; i++) begin
                slot0_q[i] <= '0;
                slot1_q[i] <= '0;
                cnt_q[i]   <= 2'd0;
            end
            stall_q     <= '0;
            ptr_q       <= '0;
            conv_push_q <= 1'b0;
            conv_x_q    <= '0;
            conv_lane_q <= '0;
            tag_vld_q   <= '0;
            for (int k = 0; k < CONV_LAT; k++) begin
                tag_lane_q[k] <= '0;
            end
        end else begin
            slot0_q     <= slot0_d;
            slot1_q     <= slot1_d;
            cnt_q       <= cnt_d;
            stall_q     <= stall_d;
            ptr_q       <= ptr_d;
            conv_push_q <= conv_push_d;
            conv_x_q    <= conv_x_d;
            conv_lane_q <= conv_lane_d;
            tag_vld_q   <= tag_vld_d;
            tag_lane_q  <= tag_lane_d;
        end
    end

    arb_out_fifo #(
        .W     (IEEE_W + TAG_W),
        .DEPTH (OUT_DEPTH)
    ) u_out_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (tag_vld_q[CONV_LAT-1]),
        .wr_data ({conv_r, tag_lane_q[CONV_LAT-1]}),
        .rd_en   (out_push),
        .rd_data (fifo_rd_data),
        .count   (fifo_count),
        .empty   (fifo_empty)
    );

    assign req_stall = stall_q;
    assign conv_push = conv_push_q;
    assign conv_x    = conv_x_q;
    assign out_push  = !fifo_empty && !out_stall;
    assign out_ieee  = fifo_rd_data[TAG_W +: IEEE_W];
    assign out_lane  = fifo_rd_data[TAG_W-1:0];

`ifdef FLOPOCO_ARB_ERR_EN
    logic [LANES-1:0] err_q, err_d;

    always_comb begin
        err_d = err_q | drop;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= '0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err_overflow = err_q;

    a_no_drop : assert property (@(posedge clk) disable iff (!rst_n) drop == '0)
        else $warning("flopoco_conv_arbiter: push dropped on full skid buffer");
`endif

endmodule

// File: tb/tb_flopoco_conv_arbiter.sv
// tb/tb_flopoco_conv_arbiter.sv - self-checking bench for flopoco_conv_arbiter
module tb_flopoco_conv_arbiter;

    localparam int LANES     = 4;
    localparam int CONV_LAT  = 3;
    localparam int OUT_DEPTH = 8;
    localparam int TAG_W     = 2;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic [LANES-1:0]      req_push = '0;
    logic [LANES*66-1:0]   req_data = '0;
    logic [LANES-1:0]      req_stall;
    logic                  conv_push;
    logic [65:0]           conv_x;
    logic [63:0]           conv_r;
    logic                  out_push;
    logic [63:0]           out_ieee;
    logic [TAG_W-1:0]      out_lane;
    logic                  out_stall = 1'b0;
`ifdef FLOPOCO_ARB_ERR_EN
    logic [LANES-1:0]      err_overflow;
`endif

    flopoco_conv_arbiter #(
        .LANES(LANES), .CONV_LAT(CONV_LAT), .OUT_DEPTH(OUT_DEPTH), .TAG_W(TAG_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .req_push(req_push), .req_data(req_data),
        .req_stall(req_stall), .conv_push(conv_push), .conv_x(conv_x),
        .conv_r(conv_r), .out_push(out_push), .out_ieee(out_ieee),
        .out_lane(out_lane), .out_stall(out_stall)
`ifdef FLOPOCO_ARB_ERR_EN
        , .err_overflow(err_overflow)
`endif
    );

    always #5 clk = ~clk;

    // Converter stand-in: fixed CONV_LAT pipeline with a simple invertible map.
    function automatic logic [63:0] fconv(input logic [65:0] x);
        return x[63:0] ^ {x[65:64], 62'b0};
    endfunction

    logic [65:0] cv_x [CONV_LAT];
    always @(posedge clk) begin
        cv_x[0] <= conv_x;
        for (int k = 1; k < CONV_LAT; k++) cv_x[k] <= cv_x[k-1];
    end
    assign conv_r = fconv(cv_x[CONV_LAT-1]);

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Scoreboard: per-lane expected results in order.
    logic [63:0] exp_q [LANES][$];
    int          out_cnt [LANES];
    int          out_total = 0;
    int          conv_cnt = 0;
    int          grant_log [$];
    logic [63:0] mon_e;

    always @(negedge clk) begin
        if (rst_n) begin
            if (conv_push) begin
                grant_log.push_back(int'(conv_x[63:60]));
                conv_cnt++;
            end
            if (out_push) begin
                out_total++;
                out_cnt[out_lane]++;
                n_checks++;
                if (exp_q[out_lane].size() == 0) begin
                    n_fail++;
                    $display("FAIL out_unexpected: lane=%0d actual=%0h required=none", out_lane, out_ieee);
                end else begin
                    mon_e = exp_q[out_lane].pop_front();
                    if (out_ieee !== mon_e) begin
                        n_fail++;
                        $display("FAIL out_data: lane=%0d actual=%0h required=%0h", out_lane, out_ieee, mon_e);
                    end
                end
            end
        end
    end

    int seq = 1;

    function automatic logic [65:0] mk(input int lane, input int s);
        logic [31:0] sv;
        sv = s;
        return {sv[1:0], 4'(lane), 28'h0, sv};
    endfunction

    function automatic int pending();
        int p = 0;
        for (int i = 0; i < LANES; i++) p += exp_q[i].size();
        return p;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int lane, input logic [65:0] d);
        req_push[lane] = 1'b1;
        req_data[lane*66 +: 66] = d;
    endtask

    int stall_toggles = 0;

    // Lanes in mask push a fresh word every cycle their stall is low.
    task automatic load(input int cycles, input logic [LANES-1:0] mask);
        logic prev;
        logic [65:0] d;
        prev = req_stall[0];
        for (int c = 0; c < cycles; c++) begin
            if (req_stall[0] != prev) stall_toggles++;
            prev = req_stall[0];
            for (int i = 0; i < LANES; i++) begin
                if (mask[i] && !req_stall[i]) begin
                    d = mk(i, seq);
                    seq++;
                    drive(i, d);
                    exp_q[i].push_back(fconv(d));
                end
            end
            tick();
            req_push = '0;
        end
    endtask

    task automatic drain(input int limit);
        int n = 0;
        while (pending() != 0 && n < limit) begin
            tick();
            n++;
        end
        chk("drain_pending", pending(), 0);
        repeat (4) tick();
    endtask

    typedef struct {
        int          lane;
        logic [65:0] data;
        int          exp_conv_cyc;
        int          exp_out_cyc;
        logic [63:0] exp_ieee;
    } vec_t;

    vec_t vecs [4];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int          conv_at, out_at, base, cnt, l1_before;
        logic [65:0] cx;
        logic [63:0] oi;
        logic [TAG_W-1:0] ol;
        logic [65:0] dd [LANES];

        vecs[0] = '{lane: 2, data: 66'h1_3FF0000000000000, exp_conv_cyc: 2, exp_out_cyc: 6, exp_ieee: 64'h7FF0000000000000};
        vecs[1] = '{lane: 0, data: 66'h2_0000000000000001, exp_conv_cyc: 2, exp_out_cyc: 6, exp_ieee: 64'h8000000000000001};
        vecs[2] = '{lane: 1, data: 66'h0_123456789ABCDEF0, exp_conv_cyc: 2, exp_out_cyc: 6, exp_ieee: 64'h123456789ABCDEF0};
        vecs[3] = '{lane: 3, data: 66'h3_C000000000000000, exp_conv_cyc: 2, exp_out_cyc: 6, exp_ieee: 64'h0000000000000000};

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        chk("rst_req_stall", req_stall, 0);
        chk("rst_conv_push", conv_push, 0);
        chk("rst_conv_x", conv_x, 0);
        chk("rst_out_push", out_push, 0);
        chk("rst_out_ieee", out_ieee, 0);
        chk("rst_out_lane", out_lane, 0);
`ifdef FLOPOCO_ARB_ERR_EN
        chk("rst_err_overflow", err_overflow, 0);
`endif
        rst_n = 1'b1;
        repeat (2) tick();

        // Table: single isolated pushes, latency and data.
        for (int v = 0; v < 4; v++) begin
            conv_at = -1;
            out_at  = -1;
            cx = '0; oi = '0; ol = '0;
            drive(vecs[v].lane, vecs[v].data);
            exp_q[vecs[v].lane].push_back(vecs[v].exp_ieee);
            for (int k = 0; k < 9; k++) begin
                @(negedge clk);
                if (conv_push && conv_at < 0) begin conv_at = k; cx = conv_x; end
                if (out_push && out_at < 0) begin out_at = k; oi = out_ieee; ol = out_lane; end
                tick();
                req_push = '0;
            end
            chk("vec_conv_cycle", conv_at, vecs[v].exp_conv_cyc);
            chk("vec_conv_x", cx, vecs[v].data);
            chk("vec_out_cycle", out_at, vecs[v].exp_out_cyc);
            chk("vec_out_lane", ol, vecs[v].lane);
            chk("vec_out_ieee", oi, vecs[v].exp_ieee);
            repeat (2) tick();
        end

        // All lanes at full rate.
        grant_log.delete();
        conv_cnt = 0;
        base = out_total;
        stall_toggles = 0;
        cnt = seq;
        load(20, 4'hF);
        chk("full_conv_every_cycle", conv_cnt, 18);
        chk("full_stall_toggles", stall_toggles >= 4, 1);
        for (int i = 0; i < 16; i++) chk("full_grant_order", grant_log[i], i % 4);
        drain(200);
        chk("full_out_total", out_total - base, seq - cnt);

        // Output stall under full load: credits cap issue at OUT_DEPTH.
        out_stall = 1'b1;
        conv_cnt = 0;
        base = out_total;
        load(30, 4'hF);
        chk("stall_issue_count", conv_cnt, OUT_DEPTH);
        chk("stall_no_out", out_total - base, 0);
        out_stall = 1'b0;
        cnt = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (out_push) cnt++;
            tick();
        end
        chk("stall_release_burst", cnt, 8);
        drain(300);

        // Overflow: lane 1 pushes three times while issue is blocked.
        out_stall = 1'b1;
        load(40, 4'b0001);
        l1_before = out_cnt[1];
        dd[0] = mk(1, seq); seq++;
        dd[1] = mk(1, seq); seq++;
        dd[2] = mk(1, seq); seq++;
        drive(1, dd[0]); exp_q[1].push_back(fconv(dd[0]));
        tick();
        chk("ovf_stall_after_first", req_stall[1], 1);
        drive(1, dd[1]); exp_q[1].push_back(fconv(dd[1]));
        tick();
        drive(1, dd[2]);
        tick();
        req_push = '0;
`ifdef FLOPOCO_ARB_ERR_EN
        chk("ovf_err_overflow", err_overflow, 4'b0010);
`endif
        out_stall = 1'b0;
        drain(300);
        chk("ovf_lane1_count", out_cnt[1] - l1_before, 2);

        // Reset with 3 results in flight and 2 in the FIFO.
        out_stall = 1'b1;
        grant_log.delete();
        for (int i = 0; i < LANES; i++) begin
            dd[i] = mk(i, seq); seq++;
            drive(i, dd[i]);
        end
        tick();
        req_push = '0;
        tick();
        drive(0, mk(0, seq)); seq++;
        tick();
        req_push = '0;
        repeat (4) tick();
        chk("rstmid_pre_out_ieee", out_ieee, fconv(dd[grant_log[0]]));
        chk("rstmid_pre_out_lane", out_lane, grant_log[0]);
        #2 rst_n = 1'b0;
        #1;
        chk("rstmid_req_stall", req_stall, 0);
        chk("rstmid_conv_push", conv_push, 0);
        chk("rstmid_conv_x", conv_x, 0);
        chk("rstmid_out_push", out_push, 0);
        chk("rstmid_out_ieee", out_ieee, 0);
        chk("rstmid_out_lane", out_lane, 0);
        for (int i = 0; i < LANES; i++) exp_q[i].delete();
        out_stall = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        base = out_total;
        repeat (10) tick();
        chk("rstmid_no_out_after", out_total - base, 0);
        grant_log.delete();
        dd[0] = mk(0, seq); seq++;
        dd[3] = mk(3, seq); seq++;
        drive(3, dd[3]); exp_q[3].push_back(fconv(dd[3]));
        drive(0, dd[0]); exp_q[0].push_back(fconv(dd[0]));
        tick();
        req_push = '0;
        repeat (4) tick();
        chk("rstmid_first_grant", grant_log[0], 0);
        chk("rstmid_second_grant", grant_log[1], 3);
        drain(100);

        // Lanes 0 and 3 only: pointer wraps from 3 back to 0.
        grant_log.delete();
        load(12, 4'b1001);
        drain(200);
        for (int i = 0; i < 8; i++) chk("wrap_grant_order", grant_log[i], (i % 2 == 0) ? 0 : 3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
